// File: rtl/layer_draw_pkg.sv
// rtl/layer_draw_pkg.sv - shared types and constants for the layer draw scheduler
package layer_draw_pkg;

    typedef logic [10:0] offset_t;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        RUN      = 1'b1
    } sched_state_t;

    localparam int FRAME_CNT_W = 16;

    // Frame counter increment; wraps silently at the counter width.
    function automatic logic [FRAME_CNT_W-1:0] frame_inc(input logic [FRAME_CNT_W-1:0] cnt);
        return cnt + FRAME_CNT_W'(1);
    endfunction

endpackage

// File: rtl/layer_draw_scheduler_if.sv
// rtl/layer_draw_scheduler_if.sv - layer request, config and arbitration result bundle
interface layer_draw_scheduler_if
    import layer_draw_pkg::*;
#(
    parameter int NUM_LAYERS = 8
);
    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    logic                          startOfFrame;
    logic [NUM_LAYERS-1:0]         drawRequest;
    offset_t [NUM_LAYERS-1:0]      offsetX;
    offset_t [NUM_LAYERS-1:0]      offsetY;
    logic                          cfg_we;
    logic [LW-1:0]                 cfg_layer;
    logic                          cfg_enable;
    logic                          cfg_blink;

    offset_t                       offset_x;
    offset_t                       offset_y;
    logic                          drawRequestOut;
    logic [LW-1:0]                 layer_id;
    logic [NUM_LAYERS-1:0]         collision_flags;
    logic                          collision_valid;
    logic [FRAME_CNT_W-1:0]        frame_count;

    modport master (
        output startOfFrame, drawRequest, offsetX, offsetY,
               cfg_we, cfg_layer, cfg_enable, cfg_blink,
        input  offset_x, offset_y, drawRequestOut, layer_id,
               collision_flags, collision_valid, frame_count
    );

    modport slave (
        input  startOfFrame, drawRequest, offsetX, offsetY,
               cfg_we, cfg_layer, cfg_enable, cfg_blink,
        output offset_x, offset_y, drawRequestOut, layer_id,
               collision_flags, collision_valid, frame_count
    );

endinterface

// File: rtl/layer_draw_scheduler_priority_enc.sv
// rtl/layer_draw_scheduler_priority_enc.sv - combinational lowest-index-first priority encoder
module layer_priority_enc #(
    parameter int WIDTH = 8,
    parameter int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/layer_draw_scheduler.sv
// rtl/layer_draw_scheduler.sv - per-pixel sprite layer arbiter with per-frame collision report; optional LAYER_BLINK_EN
module layer_draw_scheduler
    import layer_draw_pkg::*;
#(
    parameter int NUM_LAYERS  = 8,
    parameter int BLINK_SHIFT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    layer_draw_scheduler_if.slave  sif
);

    localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
    localparam logic [NUM_LAYERS-1:0] ONE = {{(NUM_LAYERS-1){1'b0}}, 1'b1};

    sched_state_t             state;
    logic [NUM_LAYERS-1:0]    layer_en;
    logic [NUM_LAYERS-1:0]    blink_mask;
    logic [NUM_LAYERS-1:0]    eligible;
    logic [NUM_LAYERS-1:0]    coll_now;
    logic [NUM_LAYERS-1:0]    coll_acc;
    logic                     multi;
    logic                     win_valid;
    logic [LW-1:0]            win_idx;

    offset_t                  offset_x_q;
    offset_t                  offset_y_q;
    logic                     draw_q;
    logic [LW-1:0]            layer_id_q;
    logic [NUM_LAYERS-1:0]    coll_flags_q;
    logic                     coll_valid_q;
    logic [FRAME_CNT_W-1:0]   frame_cnt_q;

    // Layer enable register; an index decode naturally drops out-of-range layers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_en <= '1;
        end else if (sif.cfg_we) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (sif.cfg_layer == LW'(i)) begin
                    layer_en[i] <= sif.cfg_enable;
                end
            end
        end
    end

`ifdef LAYER_BLINK_EN
    logic [NUM_LAYERS-1:0] layer_blink;

    // Layer blink register, written by the same strobe as the enables.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            layer_blink <= '0;
        end else if (sif.cfg_we) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                if (sif.cfg_layer == LW'(i)) begin
                    layer_blink[i] <= sif.cfg_blink;
                end
            end
        end
    end

    assign blink_mask = layer_blink & {NUM_LAYERS{frame_cnt_q[BLINK_SHIFT]}};
`else
    logic unused_blink;

    assign blink_mask   = '0;
    assign unused_blink = sif.cfg_blink ^ frame_cnt_q[BLINK_SHIFT];
`endif

    assign eligible = sif.drawRequest & layer_en & ~blink_mask;

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    assign multi    = |(eligible & (eligible - ONE));
    assign coll_now = multi ? eligible : '0;

    layer_priority_enc #(
        .WIDTH (NUM_LAYERS),
        .IW    (LW)
    ) u_enc (
        .req   (eligible),
        .valid (win_valid),
        .idx   (win_idx)
    );

    // Frame FSM with registered arbitration result and per-frame collision report.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= WAIT_SOF;
            offset_x_q   <= '0;
            offset_y_q   <= '0;
            draw_q       <= 1'b0;
            layer_id_q   <= '0;
            coll_acc     <= '0;
            coll_flags_q <= '0;
            coll_valid_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            coll_valid_q <= 1'b0;
            case (state)
                WAIT_SOF: begin
                    draw_q     <= 1'b0;
                    offset_x_q <= '0;
                    offset_y_q <= '0;
                    layer_id_q <= '0;
                    if (sif.startOfFrame) begin
                        // Whatever was seen before the first frame start is discarded.
                        state    <= RUN;
                        coll_acc <= '0;
                    end
                end
                RUN: begin
                    draw_q     <= win_valid;
                    offset_x_q <= win_valid ? sif.offsetX[win_idx] : '0;
                    offset_y_q <= win_valid ? sif.offsetY[win_idx] : '0;
                    layer_id_q <= win_valid ? win_idx : '0;
                    if (sif.startOfFrame) begin
                        // The start-of-frame pixel already belongs to the new frame.
                        coll_flags_q <= coll_acc;
                        coll_valid_q <= 1'b1;
                        frame_cnt_q  <= frame_inc(frame_cnt_q);
                        coll_acc     <= coll_now;
                    end else begin
                        coll_acc <= coll_acc | coll_now;
                    end
                end
                default: begin
                    state <= WAIT_SOF;
                end
            endcase
        end
    end

    assign sif.offset_x        = offset_x_q;
    assign sif.offset_y        = offset_y_q;
    assign sif.drawRequestOut  = draw_q;
    assign sif.layer_id        = layer_id_q;
    assign sif.collision_flags = coll_flags_q;
    assign sif.collision_valid = coll_valid_q;
    assign sif.frame_count     = frame_cnt_q;

endmodule

// File: tb/tb_layer_draw_scheduler.sv
// tb/tb_layer_draw_scheduler.sv - self-checking bench for layer_draw_scheduler
module tb_layer_draw_scheduler;
    import layer_draw_pkg::*;

    localparam int N = 8;

    typedef struct {
        logic       drv;
        int         id;
        offset_t    x;
        offset_t    y;
    } exp_t;

    typedef struct {
        logic [7:0] req;
        logic       drv;
        int         id;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    offset_t xs [N];
    offset_t ys [N];
    exp_t    sb [$];
    vec_t    tbl [7];
    logic    blink_on;

    layer_draw_scheduler_if #(.NUM_LAYERS(N)) sif ();

    layer_draw_scheduler #(
        .NUM_LAYERS  (N),
        .BLINK_SHIFT (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (sif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, ".offset_x"}, 32'(sif.offset_x), 0);
        chk({tag, ".offset_y"}, 32'(sif.offset_y), 0);
        chk({tag, ".drawRequestOut"}, 32'(sif.drawRequestOut), 0);
        chk({tag, ".layer_id"}, 32'(sif.layer_id), 0);
        chk({tag, ".collision_flags"}, 32'(sif.collision_flags), 0);
        chk({tag, ".collision_valid"}, 32'(sif.collision_valid), 0);
        chk({tag, ".frame_count"}, 32'(sif.frame_count), 0);
    endtask

    task automatic set_cfg(input int layer, input logic en, input logic bl);
        sif.cfg_we     = 1'b1;
        sif.cfg_layer  = 3'(layer);
        sif.cfg_enable = en;
        sif.cfg_blink  = bl;
    endtask

    // One pixel: drive at the falling edge, compare the registered result one edge later.
    task automatic cycle(input logic sof, input logic [7:0] req, input logic edrv, input int eid);
        exp_t e;
        e.drv = edrv;
        e.id  = edrv ? eid : 0;
        e.x   = edrv ? xs[eid] : '0;
        e.y   = edrv ? ys[eid] : '0;
        sb.push_back(e);
        sif.startOfFrame = sof;
        sif.drawRequest  = req;
        @(negedge clk);
        sif.cfg_we = 1'b0;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: empty, expected an entry");
        end else begin
            e = sb.pop_front();
            chk("drawRequestOut", 32'(sif.drawRequestOut), 32'(e.drv));
            chk("layer_id", 32'(sif.layer_id), 32'(e.id));
            chk("offset_x", 32'(sif.offset_x), 32'(e.x));
            chk("offset_y", 32'(sif.offset_y), 32'(e.y));
        end
    endtask

    task automatic chk_report(input string tag, input logic v, input logic [7:0] flags, input int fc);
        chk({tag, ".collision_valid"}, 32'(sif.collision_valid), 32'(v));
        if (v) begin
            chk({tag, ".collision_flags"}, 32'(sif.collision_flags), 32'(flags));
            chk({tag, ".frame_count"}, 32'(sif.frame_count), 32'(fc));
        end
    endtask

    initial begin
`ifdef LAYER_BLINK_EN
        blink_on = 1'b1;
`else
        blink_on = 1'b0;
`endif
        for (int i = 0; i < N; i++) begin
            xs[i] = 11'(100 + i * 17);
            ys[i] = 11'(500 + i * 29);
        end
        xs[1] = 11'd3;    ys[1] = 11'd4;
        xs[2] = 11'd5;    ys[2] = 11'd7;
        xs[7] = 11'h7FF;  ys[7] = 11'h400;
        for (int i = 0; i < N; i++) begin
            sif.offsetX[i] = xs[i];
            sif.offsetY[i] = ys[i];
        end

        tbl[0] = '{8'h06, 1'b1, 1};
        tbl[1] = '{8'h00, 1'b0, 0};
        tbl[2] = '{8'h80, 1'b1, 7};
        tbl[3] = '{8'hF0, 1'b1, 4};
        tbl[4] = '{8'h01, 1'b1, 0};
        tbl[5] = '{8'hFF, 1'b1, 0};
        tbl[6] = '{8'h48, 1'b1, 3};

        sif.startOfFrame = 1'b0;
        sif.drawRequest  = '0;
        sif.cfg_we       = 1'b0;
        sif.cfg_layer    = '0;
        sif.cfg_enable   = 1'b0;
        sif.cfg_blink    = 1'b0;

        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        reset = 1'b0;

        // Before the first frame start nothing is drawn.
        cycle(1'b0, 8'h06, 1'b0, 0);
        cycle(1'b1, 8'h06, 1'b0, 0);
        chk_report("first_sof", 1'b0, 8'h00, 0);

        // Arbitration table within one frame; collisions union to 0xFF.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, tbl[i].req, tbl[i].drv, tbl[i].id);
        end
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("frame1", 1'b1, 8'hFF, 1);

        // Disable layer 1: same-cycle write leaves that pixel alone.
        set_cfg(1, 1'b0, 1'b0);
        cycle(1'b0, 8'h02, 1'b1, 1);
        chk_report("pulse_end", 1'b0, 8'h00, 0);
        cycle(1'b0, 8'h06, 1'b1, 2);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("disabled_no_coll", 1'b1, 8'h00, 2);
        set_cfg(1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 0);
        cycle(1'b0, 8'h02, 1'b1, 1);

        // Single-cycle collision reported once, then a clean frame.
        cycle(1'b0, 8'h05, 1'b1, 0);
        cycle(1'b0, 8'h00, 1'b0, 0);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("coll05", 1'b1, 8'h05, 3);
        cycle(1'b0, 8'h00, 1'b0, 0);
        chk_report("coll05_pulse", 1'b0, 8'h00, 0);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("clean_frame", 1'b1, 8'h00, 4);

        // Collision on the start-of-frame pixel belongs to the new frame.
        cycle(1'b1, 8'h09, 1'b1, 0);
        chk_report("sof_coll_prev", 1'b1, 8'h00, 5);
        cycle(1'b0, 8'h00, 1'b0, 0);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("sof_coll_next", 1'b1, 8'h09, 6);

        // Blink on layer 0; frame_count=6 has bit 1 set.
        set_cfg(0, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 0);
        cycle(1'b0, 8'h03, 1'b1, blink_on ? 1 : 0);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("blink_frame6", 1'b1, blink_on ? 8'h00 : 8'h03, 7);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("blink_frame7", 1'b1, 8'h00, 8);
        cycle(1'b0, 8'h03, 1'b1, 0);

        // Reset mid-frame with requests active and layer 0 being disabled.
        set_cfg(0, 1'b0, 1'b0);
        cycle(1'b0, 8'h0F, 1'b1, 0);
        reset = 1'b1;
        sif.drawRequest = 8'h0F;
        #1;
        chk_outputs_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, 8'h30, 1'b0, 0);
        cycle(1'b1, 8'h0F, 1'b0, 0);
        chk_report("post_reset_sof", 1'b0, 8'h00, 0);
        cycle(1'b0, 8'h0F, 1'b1, 0);
        cycle(1'b1, 8'h00, 1'b0, 0);
        chk_report("post_reset_frame", 1'b1, 8'h0F, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
